operand_bank: RTL

Parametrised operand capture bank that collects NUM_OPS operands of WIDTH bits, in order, from a single input stream. It presents them as one flat vector with a valid/ack handshake to the downstream arithmetic unit. It generalises the two-register (a/b) operand loader by adding:
- configurable width and operand count;
- automatic slot sequencing;
- an undo (backspace) command;
- a dropped-input error flag.

---
 rtl/operand_bank_if.sv | 29 ++
 rtl/operand_bank.sv | 92 +++++++++
 2 files changed

// File: rtl/operand_bank_if.sv
// Operand bank bus: input stream, undo/clear controls and the flat operand
// vector with its valid/ack handshake towards the arithmetic unit.
interface operand_bank_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 2
);
  localparam int CW = $clog2(NUM_OPS + 1);

  logic                     clear;
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic                     undo;
  logic [NUM_OPS*WIDTH-1:0] ops;
  logic                     ops_valid;
  logic                     ops_ack;
  logic [CW-1:0]            count;
  logic                     drop_err;

  modport master (
    output clear, in_valid, in_data, undo, ops_ack,
    input  in_ready, ops, ops_valid, count, drop_err
  );

  modport slave (
    input  clear, in_valid, in_data, undo, ops_ack,
    output in_ready, ops, ops_valid, count, drop_err
  );
endinterface

// File: rtl/operand_bank.sv
// Operand capture bank: collects NUM_OPS operands in order from one input
// stream, supports undo of the latest capture, and hands the full set to the
// consumer through a valid/ack handshake. Dropped inputs set a sticky flag.
module operand_bank #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 2
) (
  input  logic           clk,
  input  logic           rst,
  operand_bank_if.slave  bus
);
  localparam int CW = $clog2(NUM_OPS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_OPS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] slots [NUM_OPS];
  logic [WIDTH-1:0] slots_next [NUM_OPS];
  logic             drop_flag, drop_next;

  // Next-state decode: clear beats undo/ack, which beat capture.
  always_comb begin
    state_next = state;
    count_next = count;
    drop_next  = drop_flag;
    for (int i = 0; i < NUM_OPS; i++) slots_next[i] = slots[i];

    if (bus.clear) begin
      state_next = COLLECT;
      count_next = '0;
      drop_next  = 1'b0;
      for (int i = 0; i < NUM_OPS; i++) slots_next[i] = '0;
    end else begin
      case (state)
        COLLECT: begin
          if (bus.undo) begin
            // An undo swallows any simultaneous input, even with nothing to undo.
            if (count != '0) begin
              count_next = count - ONE;
              for (int i = 0; i < NUM_OPS; i++)
                if (CW'(i) == count - ONE) slots_next[i] = '0;
            end
          end else if (bus.in_valid) begin
            for (int i = 0; i < NUM_OPS; i++)
              if (CW'(i) == count) slots_next[i] = bus.in_data;
            count_next = count + ONE;
            if (count == LAST_SLOT) state_next = FULL;
          end
        end
        FULL: begin
          if (bus.in_valid) drop_next = 1'b1;
          if (bus.ops_ack) begin
            // Slots keep their old contents; new captures overwrite them.
            state_next = COLLECT;
            count_next = '0;
          end else if (bus.undo) begin
            state_next = COLLECT;
            count_next = LAST_SLOT;
            slots_next[NUM_OPS-1] = '0;
          end
        end
      endcase
    end
  end

  // State register with synchronous reset to the empty bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      count     <= '0;
      drop_flag <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) slots[i] <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      drop_flag <= drop_next;
      for (int i = 0; i < NUM_OPS; i++) slots[i] <= slots_next[i];
    end
  end

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_ops
    assign bus.ops[g*WIDTH +: WIDTH] = slots[g];
  end

  assign bus.in_ready  = (state == COLLECT);
  assign bus.ops_valid = (state == FULL);
  assign bus.count     = count;
  assign bus.drop_err  = drop_flag;
endmodule
